// File: rtl/ect_cmd_pkg.sv
// rtl/ect_cmd_pkg.sv - shared constants, state encodings and checksum helper for the command front end
package ect_cmd_pkg;

  localparam logic [7:0] HdrByte   = 8'h55;
  localparam logic [7:0] IdleState = 8'h00;
  localparam logic [7:0] MaxCmd    = 8'h0F;

  // Command codes understood by the downstream request blocks
  localparam logic [7:0] CMD_MEAS  = 8'h06;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_CMD  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [1:0] {S_HDR, S_CMD, S_ARG, S_CHK} parse_state_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REL} run_state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] arg);
    return cmd ^ arg ^ HdrByte;
  endfunction

endpackage

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - byte strobe, HDR/CMD/ARG/CHK framing, byte-gap timer and frame checks
module uart_frame_parser
  import ect_cmd_pkg::*;
#(
  parameter logic [15:0] ByteTimeout = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       hold,
  output logic       frame_valid,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       err,
  output logic [1:0] err_code
);

  parse_state_t state_q, state_d;
  logic         rdy_q;
  logic [15:0]  gap_q, gap_d;
  logic [7:0]   cmd_q, cmd_d, arg_q, arg_d;
  logic         stb;
  logic         gap_hit;

  // While the top is executing a command, strobes are swallowed but the edge register keeps tracking
  assign stb     = rx_ready & ~rdy_q & ~hold;
  assign gap_hit = (gap_q == ByteTimeout - 16'd1);
  assign cmd     = cmd_q;
  assign arg     = arg_q;

  // Framing state register, ready-edge register, byte-gap timer and latched fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      rdy_q   <= 1'b0;
      gap_q   <= 16'd0;
      cmd_q   <= 8'd0;
      arg_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rx_ready;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
    end
  end

  // Next-state decode; a strobe always beats a coincident gap expiry
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    frame_valid = 1'b0;
    err         = 1'b0;
    err_code    = ERR_NONE;

    if (state_q == S_HDR || stb) gap_d = 16'd0;
    else                         gap_d = gap_q + 16'd1;

    case (state_q)
      S_HDR: begin
        if (stb && rx_data == HdrByte) state_d = S_CMD;
      end
      S_CMD: begin
        if (stb) begin
          cmd_d   = rx_data;
          state_d = S_ARG;
        end else if (gap_hit) begin
          err      = 1'b1;
          err_code = ERR_TMO;
          state_d  = S_HDR;
        end
      end
      S_ARG: begin
        if (stb) begin
          arg_d   = rx_data;
          state_d = S_CHK;
        end else if (gap_hit) begin
          err      = 1'b1;
          err_code = ERR_TMO;
          state_d  = S_HDR;
        end
      end
      S_CHK: begin
        if (stb) begin
          state_d = S_HDR;
          if (rx_data != frame_chk(cmd_q, arg_q)) begin
            err      = 1'b1;
            err_code = ERR_CHK;
          end else if (cmd_q == 8'd0 || cmd_q > MaxCmd) begin
            err      = 1'b1;
            err_code = ERR_CMD;
          end else begin
            frame_valid = 1'b1;
          end
        end else if (gap_hit) begin
          err      = 1'b1;
          err_code = ERR_TMO;
          state_d  = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// rtl/uart_cmd_dispatcher.sv - command execute handshake, Done timer and error reporting around the frame parser
module uart_cmd_dispatcher
  import ect_cmd_pkg::*;
#(
  parameter logic [15:0] ByteTimeout = 16'd50000,
  parameter logic [23:0] DoneTimeout = 24'd10000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       UARTDatReady,
  input  logic [7:0] UARTReceive,
  input  logic       Done,
  output logic [7:0] SysState,
  output logic       Enable,
  output logic [7:0] CmdArg,
  output logic       Busy,
  output logic       ErrPulse,
  output logic [1:0] ErrCode,
  output logic [7:0] ErrCnt
);

  run_state_t  run_q, run_d;
  logic [23:0] tmr_q, tmr_d;
  logic [7:0]  sys_d, arg_d;
  logic        en_d, busy_d;
  logic        err_ev;
  logic [1:0]  err_code_ev;

  logic        frame_valid;
  logic [7:0]  p_cmd, p_arg;
  logic        p_err;
  logic [1:0]  p_err_code;

  uart_frame_parser #(.ByteTimeout(ByteTimeout)) u_parser (
    .clk         (Clk),
    .rst         (Rst),
    .rx_ready    (UARTDatReady),
    .rx_data     (UARTReceive),
    .hold        (run_q != S_IDLE),
    .frame_valid (frame_valid),
    .cmd         (p_cmd),
    .arg         (p_arg),
    .err         (p_err),
    .err_code    (p_err_code)
  );

  // Handshake state, outputs, Done timer and saturating error bookkeeping
  always_ff @(posedge Clk) begin
    if (Rst) begin
      run_q    <= S_IDLE;
      tmr_q    <= 24'd0;
      SysState <= IdleState;
      CmdArg   <= 8'd0;
      Enable   <= 1'b0;
      Busy     <= 1'b0;
      ErrPulse <= 1'b0;
      ErrCode  <= ERR_NONE;
      ErrCnt   <= 8'd0;
    end else begin
      run_q    <= run_d;
      tmr_q    <= tmr_d;
      SysState <= sys_d;
      CmdArg   <= arg_d;
      Enable   <= en_d;
      Busy     <= busy_d;
      ErrPulse <= err_ev;
      if (err_ev) begin
        ErrCode <= err_code_ev;
        if (ErrCnt != 8'hFF) ErrCnt <= ErrCnt + 8'd1;
      end
    end
  end

  // Accept a checked frame, hold Enable until Done (or timeout), then wait for Done to drop
  always_comb begin
    run_d       = run_q;
    sys_d       = SysState;
    arg_d       = CmdArg;
    en_d        = Enable;
    busy_d      = Busy;
    tmr_d       = 24'd0;
    err_ev      = p_err;
    err_code_ev = p_err_code;

    case (run_q)
      S_IDLE: begin
        if (frame_valid) begin
          run_d  = S_RUN;
          sys_d  = p_cmd;
          arg_d  = p_arg;
          en_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
      S_RUN: begin
        tmr_d = tmr_q + 24'd1;
        if (Done) begin
          run_d = S_REL;
          en_d  = 1'b0;
          sys_d = IdleState;
        end else if (tmr_q == DoneTimeout - 24'd1) begin
          run_d       = S_REL;
          en_d        = 1'b0;
          sys_d       = IdleState;
          err_ev      = 1'b1;
          err_code_ev = ERR_TMO;
        end
      end
      S_REL: begin
        if (!Done) begin
          run_d  = S_IDLE;
          busy_d = 1'b0;
        end
      end
      default: run_d = S_IDLE;
    endcase
  end

endmodule
